quad_encoder_capture: RTL

QUAD_ENCODER_CAPTURE -- requirements
Module: quad_encoder_capture

---
 rtl/quad_encoder_capture_pkg.sv | 28 ++
 rtl/enc_glitch_filter.sv | 44 ++++
 rtl/quad_encoder_capture.sv | 137 +++++++++++++
 3 files changed

// File: rtl/quad_encoder_capture_pkg.sv
// Shared defaults and step encoding for the quadrature encoder capture block.
// The decode function maps a previous/current filtered {A,B} pair to a step code.
package quad_encoder_capture_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int FILT_LEN_DEF = 3;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_INC  = 2'b01,
    STEP_DEC  = 2'b10,
    STEP_ILL  = 2'b11
  } step_e;

  // Forward sequence is 00->01->11->10->00; a two-bit change is illegal
  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e s;
    s = STEP_NONE;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_INC;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: s = STEP_DEC;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: s = STEP_ILL;
      default:                            s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// One encoder channel: 2-flop synchronizer followed by a stability filter.
// The filtered level follows the synchronized level once it has differed for FILT_LEN clocks.
module enc_glitch_filter
  import quad_encoder_capture_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic       sync1_r;
  logic       sync2_r;
  logic       filt_r;
  logic [3:0] cnt_r;

  // Synchronizer and filter counter; counter restarts whenever raw matches filtered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      filt_r  <= 1'b0;
      cnt_r   <= 4'd0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r == filt_r) begin
        cnt_r <= 4'd0;
      end else if (cnt_r == CNT_LAST) begin
        filt_r <= sync2_r;
        cnt_r  <= 4'd0;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end
    end
  end

  assign filt = filt_r;

endmodule

// File: rtl/quad_encoder_capture.sv
// Quadrature encoder capture: filtered decode, saturating signed window count,
// and snapshot/clear handshake with the control sequencer.
module quad_encoder_capture
  import quad_encoder_capture_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             cod_start,
  input  logic             cod_clr,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  output logic             enc_err,
  output logic             cnt_sat
);

  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                    filt_a_s;
  logic                    filt_b_s;
  logic [1:0]              cur_s;
  logic [1:0]              prev_r;
  step_e                   step_s;
  logic                    run_r;
  logic                    run_eff_s;
  logic signed [CNT_W-1:0] count_r;
  logic signed [CNT_W-1:0] base_s;
  logic signed [CNT_W-1:0] count_nxt_s;
  logic signed [CNT_W-1:0] cnt_out_r;
  logic                    sat_hit_s;
  logic                    sat_nxt_s;
  logic                    err_nxt_s;
  logic                    cnt_valid_r;
  logic                    enc_err_r;
  logic                    cnt_sat_r;

  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (enc_a),
    .filt  (filt_a_s)
  );

  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (enc_b),
    .filt  (filt_b_s)
  );

  assign cur_s  = {filt_a_s, filt_b_s};
  assign step_s = decode_step(prev_r, cur_s);

  // Next window count, saturation and error flags; a clear restarts the window from zero
  always_comb begin
    run_eff_s   = run_r | cod_start;
    base_s      = count_r;
    count_nxt_s = count_r;
    sat_hit_s   = 1'b0;
    sat_nxt_s   = cnt_sat_r;
    err_nxt_s   = enc_err_r;

    if (cod_clr) begin
      base_s = '0;
    end else begin
      base_s = count_r;
    end
    count_nxt_s = base_s;

    if (run_eff_s) begin
      case (step_s)
        STEP_INC: begin
          if (base_s == CNT_MAX) begin
            sat_hit_s = 1'b1;
          end else begin
            count_nxt_s = base_s + CNT_ONE;
          end
        end
        STEP_DEC: begin
          if (base_s == CNT_MIN) begin
            sat_hit_s = 1'b1;
          end else begin
            count_nxt_s = base_s - CNT_ONE;
          end
        end
        default: count_nxt_s = base_s;
      endcase
    end else begin
      count_nxt_s = base_s;
    end

    if (cod_clr) begin
      sat_nxt_s = sat_hit_s;
      err_nxt_s = (step_s == STEP_ILL);
    end else begin
      sat_nxt_s = cnt_sat_r | sat_hit_s;
      err_nxt_s = enc_err_r | (step_s == STEP_ILL);
    end
  end

  // State registers; the snapshot takes the count before this cycle's step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r      <= 2'b00;
      run_r       <= 1'b0;
      count_r     <= '0;
      cnt_out_r   <= '0;
      cnt_valid_r <= 1'b0;
      enc_err_r   <= 1'b0;
      cnt_sat_r   <= 1'b0;
    end else begin
      prev_r      <= cur_s;
      run_r       <= run_r | cod_start;
      count_r     <= count_nxt_s;
      cnt_valid_r <= cod_clr;
      enc_err_r   <= err_nxt_s;
      cnt_sat_r   <= sat_nxt_s;
      if (cod_clr) begin
        cnt_out_r <= count_r;
      end else begin
        cnt_out_r <= cnt_out_r;
      end
    end
  end

  assign cnt_out   = cnt_out_r;
  assign cnt_valid = cnt_valid_r;
  assign enc_err   = enc_err_r;
  assign cnt_sat   = cnt_sat_r;

endmodule
